// File: rtl/pc_controller_pkg.sv
// Shared widths and defaults for the PC controller slice.
// Optional feature macro used by this slice: PC_STALL_EN (adds the stall input).
package pc_controller_pkg;
  localparam int          NUM_FASES    = 10;
  localparam int          FASE_W       = 4;
  localparam int          DATA_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef logic [DATA_W-1:0] pc_t;
  typedef logic [FASE_W-1:0] fase_t;
endpackage

// File: rtl/pc_controller_fase.sv
// Instruction phase counter: counts 0..N-1 and wraps, advancing only when enabled.
module contador_fase
  import pc_controller_pkg::*;
#(
  parameter int N = NUM_FASES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [FASE_W-1:0] fase
);
  localparam fase_t LAST = FASE_W'(N - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       fase <= '0;
    else if (enable) fase <= (fase == LAST) ? '0 : fase + FASE_W'(1);
  end
endmodule

// File: rtl/pc_controller.sv
// Phase-sequenced program counter with a deferred branch window.
// Define PC_STALL_EN to add the stall input that freezes the whole block.
module pc_controller #(
  parameter logic [31:0] RESET_PC     = pc_controller_pkg::RESET_PC_DEF,
  parameter int          PC_INCR      = 1,
  parameter int          NUM_FASES    = pc_controller_pkg::NUM_FASES,
  parameter int          FASE_CAPTURA = 5,
  parameter int          FASE_ATUALIZA = 9
) (
  input  logic                                clock,
  input  logic                                reset,
`ifdef PC_STALL_EN
  input  logic                                stall,
`endif
  input  logic [pc_controller_pkg::DATA_W-1:0] entrada_mux,
  input  logic                                branch_taken,
  output logic [pc_controller_pkg::DATA_W-1:0] estado_pc,
  output logic [pc_controller_pkg::FASE_W-1:0] fase,
  output logic                                pc_atualizado
);
  import pc_controller_pkg::*;

  localparam fase_t CAP  = FASE_W'(FASE_CAPTURA);
  localparam fase_t ATU  = FASE_W'(FASE_ATUALIZA);
  localparam pc_t   INCR = DATA_W'(PC_INCR);

  logic run;
  logic desvio_pendente;
  pc_t  alvo;
  logic em_janela;
  logic em_atualiza;

`ifdef PC_STALL_EN
  assign run = ~stall;
`else
  assign run = 1'b1;
`endif

  assign em_janela   = (fase >= CAP) && (fase < ATU);
  assign em_atualiza = (fase == ATU);

  contador_fase #(.N(NUM_FASES)) u_fase (
    .clock  (clock),
    .reset  (reset),
    .enable (run),
    .fase   (fase)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_pc       <= RESET_PC;
      pc_atualizado   <= 1'b0;
      desvio_pendente <= 1'b0;
      alvo            <= '0;
    end else begin
      pc_atualizado <= 1'b0;
      if (run) begin
        if (em_atualiza) begin
          // a request captured earlier in the window beats a same-cycle request
          if (desvio_pendente)   estado_pc <= alvo;
          else if (branch_taken) estado_pc <= entrada_mux;
          else                   estado_pc <= estado_pc + INCR;
          desvio_pendente <= 1'b0;
          pc_atualizado   <= 1'b1;
        end else if (em_janela && branch_taken && !desvio_pendente) begin
          desvio_pendente <= 1'b1;
          alvo            <= entrada_mux;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: directed scenarios plus random traffic vs a reference model.
module tb_pc_controller;
  import pc_controller_pkg::*;

  localparam int          NF  = 10;
  localparam int          CAP = 5;
  localparam int          ATU = 9;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] entrada_mux = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] estado_pc;
  logic [3:0]  fase;
  logic        pc_atualizado;
`ifdef PC_STALL_EN
  logic        stall = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model: phase = non-stalled cycles since reset mod NF,
  // window requests queued in arrival order, first one taken at update
  int          m_ph;
  logic [31:0] m_pc;
  logic        m_pulse;
  logic [31:0] win_q[$];

  always #5 clock = ~clock;

  pc_controller #(
    .RESET_PC(RPC), .PC_INCR(1), .NUM_FASES(NF),
    .FASE_CAPTURA(CAP), .FASE_ATUALIZA(ATU)
  ) dut (
    .clock         (clock),
    .reset         (reset),
`ifdef PC_STALL_EN
    .stall         (stall),
`endif
    .entrada_mux   (entrada_mux),
    .branch_taken  (branch_taken),
    .estado_pc     (estado_pc),
    .fase          (fase),
    .pc_atualizado (pc_atualizado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".fase"}, {28'd0, fase}, m_ph);
    chk({tag, ".pc"}, estado_pc, m_pc);
    chk({tag, ".pulse"}, {31'd0, pc_atualizado}, {31'd0, m_pulse});
  endtask

  task automatic model_reset();
    m_ph = 0; m_pc = RPC; m_pulse = 1'b0; win_q.delete();
  endtask

  task automatic model_edge(input bit br, input logic [31:0] mux, input bit st);
    m_pulse = 1'b0;
    if (st) return;
    if (m_ph == ATU) begin
      if (win_q.size() > 0) m_pc = win_q[0];
      else if (br)          m_pc = mux;
      else                  m_pc = m_pc + 32'd1;
      win_q.delete();
      m_pulse = 1'b1;
    end else if (m_ph >= CAP && m_ph < ATU && br) begin
      win_q.push_back(mux);
    end
    m_ph = (m_ph + 1) % NF;
  endtask

  // drive inputs, take one edge, advance model, sample 1 time unit later
  task automatic tick(input bit br, input logic [31:0] mux, input bit st, input bit check);
    branch_taken = br;
    entrada_mux  = mux;
`ifdef PC_STALL_EN
    stall = st;
`endif
    @(posedge clock);
    model_edge(br, mux, st);
    #1;
    if (check) chk_model("step");
  endtask

  task automatic run_to(input int ph);
    int guard = 0;
    while (m_ph != ph && guard < 2 * NF) begin
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      guard++;
    end
    if (m_ph != ph) chk("run_to_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    model_reset();
    #12;
    chk_model("reset_state");
    reset = 1'b0;

    // free-running from reset: 0,1,2,3 and a pulse every NF cycles
    for (int k = 1; k <= 3; k++) begin
      for (int c = 0; c < NF; c++) tick(1'b0, 32'h0, 1'b0, 1'b1);
      chk("seq_pc", estado_pc, k);
      chk("seq_pulse", {31'd0, pc_atualizado}, 32'd1);
    end

    // first capture in the window wins
    run_to(6); tick(1'b1, 32'h40, 1'b0, 1'b1);
    tick(1'b1, 32'h80, 1'b0, 1'b1);
    run_to(9); tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("first_wins", estado_pc, 32'h40);

    // same-cycle request at the update phase; out-of-window request ignored
    run_to(9); tick(1'b1, 32'h24, 1'b0, 1'b1);
    chk("same_cycle", estado_pc, 32'h24);
    run_to(3); tick(1'b1, 32'h24, 1'b0, 1'b1);
    run_to(9); tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("outside_window", estado_pc, 32'h25);

    // 32-bit wrap
    run_to(9); tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("to_max", estado_pc, 32'hFFFF_FFFF);
    run_to(9); tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("wrap", estado_pc, 32'h0);

    // reset mid-cycle with a pending branch
    run_to(6); tick(1'b1, 32'h100, 1'b0, 1'b1);
    branch_taken = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_model("async_reset");
    @(negedge clock); reset = 1'b0;
    run_to(9); tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("post_reset_pc", estado_pc, RPC + 32'd1);

`ifdef PC_STALL_EN
    // stall at the update phase delays the update by 3 cycles
    run_to(9);
    for (int s = 0; s < 3; s++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b1);
      chk("stall_fase", {28'd0, fase}, 32'd9);
      chk("stall_pulse", {31'd0, pc_atualizado}, 32'd0);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_update", estado_pc, RPC + 32'd2);
`endif

    // random traffic against the model
    for (int r = 0; r < 400; r++) begin
      bit          br;
      bit          st;
      logic [31:0] mux;
      br  = ($urandom_range(0, 9) < 3);
      mux = $urandom();
      st  = 1'b0;
`ifdef PC_STALL_EN
      st  = ($urandom_range(0, 9) == 0);
`endif
      tick(br, mux, st, 1'b1);
    end

    branch_taken = 1'b0;
`ifdef PC_STALL_EN
    stall = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_controller.md
PC_CONTROLLER -- requirements
Module: pc_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the value loaded into estado_pc on reset.
REQ-002 The block SHALL have parameter PC_INCR, default 1, the sequential increment in word displacements.
REQ-003 The block SHALL have parameter NUM_FASES, default 10, the length of the instruction phase cycle.
REQ-004 The block SHALL have parameter FASE_CAPTURA, default 5, the first phase in which a branch request is accepted.
REQ-005 The block SHALL have parameter FASE_ATUALIZA, default 9, the phase in which the PC is updated.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port entrada_mux, input, 32 bits: branch target from the target adder.
REQ-009 The block SHALL have port branch_taken, input, 1 bit: branch condition true, qualified by phase.
REQ-010 The block SHALL have port estado_pc, output, 32 bits: current PC in word displacements.
REQ-011 The block SHALL have port fase, output, 4 bits: current phase, 0..NUM_FASES-1.
REQ-012 The block SHALL have port pc_atualizado, output, 1 bit: one-cycle pulse after each PC update.
REQ-013 Under PC_STALL_EN, the block SHALL have port stall, input, 1 bit: freeze request.

Function
REQ-014 fase SHALL advance by 1 per non-stalled clock and wrap from NUM_FASES-1 to 0.
REQ-015 Branch window: in phases FASE_CAPTURA..FASE_ATUALIZA-1, branch_taken=1 SHALL set desvio_pendente and capture entrada_mux into alvo; first capture wins, later requests in the window are ignored.
REQ-016 branch_taken outside phases FASE_CAPTURA..FASE_ATUALIZA SHALL be ignored.
REQ-017 On the edge where fase==FASE_ATUALIZA, estado_pc SHALL load alvo if desvio_pendente, else entrada_mux if branch_taken=1 (same-cycle request), else estado_pc+PC_INCR.
REQ-018 The same update edge SHALL clear desvio_pendente.
REQ-019 pc_atualizado SHALL be 1 for exactly the cycle following each update edge; latency is update edge to pulse in 1 cycle.
REQ-020 PC arithmetic SHALL be 32-bit unsigned modulo 2^32; 32'hFFFF_FFFF+1 wraps to 0 with no flag.
REQ-021 estado_pc SHALL change only on an update edge or on reset.

Reset
REQ-022 Reset SHALL force estado_pc=RESET_PC, fase=0, pc_atualizado=0, desvio_pendente=0, alvo=0 asynchronously.
REQ-023 Reset asserted mid-cycle SHALL discard any pending branch; after release, counting SHALL resume from phase 0 on the first clock edge.

Configuration
REQ-024 With PC_STALL_EN defined, stall=1 SHALL hold fase, estado_pc, desvio_pendente and alvo, SHALL force pc_atualizado=0, and SHALL block branch capture that cycle.
REQ-025 Without PC_STALL_EN, the stall port SHALL be absent and the block SHALL never stall.

Structure
REQ-026 Package pc_controller_pkg SHALL hold NUM_FASES, the phase width (4), the data width (32), and the default RESET_PC.
REQ-027 The phase counter SHALL be the sub-module contador_fase, with ports clock, reset, enable, and fase.

Verification
REQ-028 The bench SHALL cover reset release with branch_taken=0 for 30 cycles: estado_pc=0,1,2,3 after successive phase-9 edges, and pc_atualizado pulses every 10 cycles.
REQ-029 The bench SHALL cover branch_taken=1 with entrada_mux=32'h40 in phase 6, and entrada_mux=32'h80 with branch_taken=1 in phase 7: the next update gives estado_pc=32'h40.
REQ-030 The bench SHALL cover branch_taken=1 only in phase 9 with entrada_mux=32'h24: estado_pc=32'h24; the same request in phase 3 SHALL leave estado_pc=old+1.
REQ-031 The bench SHALL cover estado_pc=32'hFFFF_FFFF with no branch: the update gives estado_pc=0.
REQ-032 The bench SHALL cover reset asserted in phase 7 with a pending branch to 32'h100: after release, estado_pc=RESET_PC and the first update gives RESET_PC+1.
REQ-033 With PC_STALL_EN, the bench SHALL cover stall=1 for 3 cycles at phase 9: the update is delayed by 3 cycles, fase holds at 9, and pc_atualizado stays 0 while stalled.
